// File: rtl/ifid_pipe_buf_if.sv
// Fetch/decode handshake bundle for ifid_pipe_buf.
// master: the surrounding pipeline (fetch offers, decode consumes); slave: the buffer.
interface ifid_pipe_buf_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              if_valid;
  logic              if_ready;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              id_valid;
  logic              id_ready;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;

  modport master (
    output if_valid, if_pc, if_inst, id_ready,
    input  if_ready, id_valid, id_pc, id_inst
  );

  modport slave (
    input  if_valid, if_pc, if_inst, id_ready,
    output if_ready, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/ifid_pipe_buf.sv
// In-order {pc, inst} FIFO between fetch and decode with flush and optional
// decode back-pressure counter (enabled by defining IFID_STALL_CNT_EN).
module ifid_pipe_buf #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  ifid_pipe_buf_if.slave           bus,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              stall_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;

  assign bus.if_ready = (count < (AW+1)'(DEPTH));
  assign bus.id_valid = (count != '0);
  assign occupancy    = count;

  assign push = bus.if_valid && bus.if_ready && !flush;
  assign pop  = bus.id_valid && bus.id_ready && !flush;

  // DEPTH is a power of two, so pointer increments wrap without an explicit compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= bus.if_pc;
      inst_mem[wr_ptr] <= bus.if_inst;
    end
  end

  // Storage is unreset; an empty buffer presents zeros (nop) instead.
  assign bus.id_pc   = bus.id_valid ? pc_mem[rd_ptr]   : '0;
  assign bus.id_inst = bus.id_valid ? inst_mem[rd_ptr] : '0;

`ifdef IFID_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.id_valid && !bus.id_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_pipe_buf.sv
// Scoreboard bench for ifid_pipe_buf: DEPTH=2 and DEPTH=4 instances share stimulus,
// each checked against its own queue-based reference model.
module tb_ifid_pipe_buf;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;

  logic [1:0]  occ2;
  logic [2:0]  occ4;
  logic [31:0] st2, st4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifid_pipe_buf_if #(.PC_W(32), .INST_W(32)) b2 ();
  ifid_pipe_buf_if #(.PC_W(32), .INST_W(32)) b4 ();

  assign b2.if_valid = if_valid;
  assign b2.if_pc    = if_pc;
  assign b2.if_inst  = if_inst;
  assign b2.id_ready = id_ready;
  assign b4.if_valid = if_valid;
  assign b4.if_pc    = if_pc;
  assign b4.if_inst  = if_inst;
  assign b4.id_ready = id_ready;

  ifid_pipe_buf #(.PC_W(32), .INST_W(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .bus(b2), .flush(flush), .occupancy(occ2), .stall_cnt(st2)
  );
  ifid_pipe_buf #(.PC_W(32), .INST_W(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .bus(b4), .flush(flush), .occupancy(occ4), .stall_cnt(st4)
  );

  logic        o_valid [2];
  logic        o_ready [2];
  logic [31:0] o_pc    [2];
  logic [31:0] o_inst  [2];
  logic [31:0] o_occ   [2];
  logic [31:0] o_stall [2];

  assign o_valid[0] = b2.id_valid;
  assign o_ready[0] = b2.if_ready;
  assign o_pc[0]    = b2.id_pc;
  assign o_inst[0]  = b2.id_inst;
  assign o_occ[0]   = {30'd0, occ2};
  assign o_stall[0] = st2;
  assign o_valid[1] = b4.id_valid;
  assign o_ready[1] = b4.if_ready;
  assign o_pc[1]    = b4.id_pc;
  assign o_inst[1]  = b4.id_inst;
  assign o_occ[1]   = {29'd0, occ4};
  assign o_stall[1] = st4;

  // Reference model: expected contents per instance, in arrival order.
  pair_t exp_q [2][$];
  int    depth_k [2] = '{2, 4};
  int    npush   [2] = '{0, 0};
  int    stall_m [2] = '{0, 0};
  int    popped  [2] = '{0, 0};

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s depth=%0d actual=%h required=%h t=%0t", nm, depth_k[k], act, exp, $time);
    end
  endtask

  function automatic logic [31:0] stall_exp(input int k);
`ifdef IFID_STALL_CNT_EN
    return 32'(stall_m[k]);
`else
    return 32'(k - k);
`endif
  endfunction

  // Stimulus: one call per cycle, inputs applied 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic fl, input logic rdy);
    pair_t p;
    @(posedge clk);
    #1;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    flush    = fl;
    id_ready = rdy;
    p.pc   = pc;
    p.inst = inst;
    for (int k = 0; k < 2; k++) begin
      npush[k] = 0;
      if (v && !fl && (exp_q[k].size() < depth_k[k])) begin
        exp_q[k].push_back(p);
        npush[k] = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    if_valid = 1'b0;
    flush    = 1'b0;
    id_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      npush[k]   = 0;
      stall_m[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: mid-cycle, compare visible state and retire this cycle's pop/flush.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk("rst_occupancy", k, o_occ[k], 32'd0);
        chk("rst_id_valid", k, 32'(o_valid[k]), 32'd0);
        chk("rst_if_ready", k, 32'(o_ready[k]), 32'd1);
        chk("rst_stall_cnt", k, o_stall[k], 32'd0);
      end else begin
        int    eocc;
        pair_t head;
        eocc = exp_q[k].size() - npush[k];
        head = (eocc > 0) ? exp_q[k][0] : '0;
        chk("occupancy", k, o_occ[k], 32'(eocc));
        chk("id_valid", k, 32'(o_valid[k]), 32'(eocc != 0));
        chk("if_ready", k, 32'(o_ready[k]), 32'(eocc < depth_k[k]));
        chk("id_pc", k, o_pc[k], head.pc);
        chk("id_inst", k, o_inst[k], head.inst);
        chk("stall_cnt", k, o_stall[k], stall_exp(k));
        if (flush) begin
          exp_q[k].delete();
        end else if (eocc > 0) begin
          if (id_ready) begin
            void'(exp_q[k].pop_front());
            popped[k]++;
          end else begin
            stall_m[k]++;
          end
        end
      end
      npush[k] = 0;
    end
  end

  initial begin
    int i;
    int budget;
    int base;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset
    drive(0, 0, 0, 0, 0);
    chk("idle_id_valid", 0, 32'(b2.id_valid), 32'd0);
    chk("idle_id_inst", 0, b2.id_inst, 32'd0);
    chk("idle_if_ready", 0, 32'(b2.if_ready), 32'd1);

    // Single push with decode ready: visible after one edge, gone after the next
    drive(1, 32'h100, 32'h24020005, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("lat_id_pc", 0, b2.id_pc, 32'h100);
    chk("lat_id_inst", 0, b2.id_inst, 32'h24020005);
    drive(0, 0, 0, 0, 1);
    chk("lat_drained", 0, 32'(b2.id_valid), 32'd0);

    // Fill with decode stalled, third offer refused, then drain in order
    drive(1, 32'h100, 32'hA0, 0, 0);
    drive(1, 32'h104, 32'hA4, 0, 0);
    drive(1, 32'h108, 32'hA8, 0, 0);
    chk("full_occupancy", 0, {30'd0, occ2}, 32'd2);
    chk("full_if_ready", 0, 32'(b2.if_ready), 32'd0);
    drive(0, 0, 0, 0, 1);
    chk("drain_first", 0, b2.id_pc, 32'h100);
    drive(0, 0, 0, 0, 1);
    chk("drain_second", 0, b2.id_pc, 32'h104);
    drive(0, 0, 0, 0, 1);
    chk("drain_empty", 0, 32'(b2.id_valid), 32'd0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // Flush while full and an offer is present
    drive(1, 32'h200, 32'hB0, 0, 0);
    drive(1, 32'h204, 32'hB4, 0, 0);
    drive(1, 32'h300, 32'hC0, 1, 0);
    drive(0, 0, 0, 0, 0);
    chk("flush_occ_d2", 0, {30'd0, occ2}, 32'd0);
    chk("flush_occ_d4", 1, {29'd0, occ4}, 32'd0);
    chk("flush_valid", 0, 32'(b2.id_valid), 32'd0);

    // Stall counter: 5 edges with a head present and decode not ready
    do_reset();
    drive(1, 32'h400, 32'hD0, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
`ifdef IFID_STALL_CNT_EN
    chk("stall_five", 0, st2, 32'd5);
`else
    chk("stall_off", 0, st2, 32'd0);
`endif
    drive(0, 0, 0, 0, 1);

    // Stream 10 pairs with decode ready toggling each cycle
    do_reset();
    base   = popped[1];
    i      = 0;
    budget = 0;
    while (i < 10 && budget < 200) begin
      drive(1, 32'h1000 + 32'(i) * 4, 32'hE000 + 32'(i), 0, budget[0]);
      if (npush[1] != 0) i++;
      budget++;
    end
    repeat (12) drive(0, 0, 0, 0, 1);
    chk("stream_delivered", 1, 32'(popped[1] - base), 32'd10);

    // Randomised traffic with occasional flush and mid-run reset
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 3) != 0, $urandom, $urandom,
              $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      end
    end
    repeat (6) drive(0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifid_pipe_buf.md
IFID_PIPE_BUF -- requirements
Module: ifid_pipe_buf

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning:
- PC_W  32  fetch address width
- INST_W  32  instruction width
- DEPTH  2  buffer entries; power of two, >= 2
REQ-002 The block SHALL have ports, one per line: name  direction  width  meaning:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  fetch offers a pc/inst pair
- if_ready  out  1  buffer accepts offer this cycle
- if_pc  in  PC_W  fetch address
- if_inst  in  INST_W  fetched instruction
- flush  in  1  discard all buffered and offered entries (branch/exception redirect)
- id_valid  out  1  head entry present
- id_ready  in  1  decode consumes head this cycle
- id_pc  out  PC_W  head address
- id_inst  out  INST_W  head instruction
- occupancy  out  log2(DEPTH)+1  current entry count
- stall_cnt  out  32  decode back-pressure cycle count (see Configuration)

Function
REQ-003 The block SHALL be a DEPTH-entry in-order FIFO of {pc, inst} pairs between fetch and decode.
REQ-004 Push SHALL occur on a rising edge where if_valid && if_ready && !flush.
REQ-005 Pop SHALL occur on a rising edge where id_valid && id_ready && !flush.
REQ-006 if_ready SHALL equal (occupancy < DEPTH); it SHALL NOT depend combinationally on id_ready.
REQ-007 id_valid SHALL equal (occupancy != 0); id_pc/id_inst SHALL show the oldest entry, taken only from registers.
REQ-008 When id_valid=0, id_pc and id_inst SHALL be all-zero (zero instruction = nop).
REQ-009 Latency: a pair pushed at edge N SHALL be visible on id_* after edge N if the buffer was empty; there is no same-cycle bypass.
REQ-010 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; this is legal when full only if if_ready=0, so no push then.
REQ-011 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy SHALL be tracked separately to distinguish full from empty.
REQ-012 flush=1 at an edge SHALL set occupancy to 0 and pointers to 0, and SHALL drop any offer that same cycle; flush has priority over push and pop.
REQ-013 Push to a full buffer and pop from an empty buffer SHALL be impossible by construction; stored state SHALL not change in those cases.
REQ-014 Stored entries SHALL not be altered while occupancy is held (stall): id_* stable until pop or flush.

Reset
REQ-015 rst=1 SHALL asynchronously clear occupancy, pointers and stall_cnt to 0, giving id_valid=0, id_pc=0, id_inst=0, if_ready=1.
REQ-016 Reset asserted mid-operation SHALL discard all entries; no partial state SHALL survive deassertion.
REQ-017 Storage array contents need not be reset; outputs SHALL be masked per REQ-008.

Configuration
REQ-018 Macro IFID_STALL_CNT_EN SHALL control the statistics counter.
REQ-019 With IFID_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 on each edge where id_valid && !id_ready && !flush, saturating at 32'hFFFFFFFF, cleared only by rst.
REQ-020 Without IFID_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-021 Bench SHALL cover, DEPTH=2 unless stated:
- Reset then idle -> id_valid=0, id_inst=0, if_ready=1, occupancy=0.
- Push pc=0x100 inst=0x24020005 with id_ready=1 -> next cycle id_pc=0x100, id_inst=0x24020005; following cycle id_valid=0.
- id_ready=0, push 0x100,0x104 -> occupancy=2, if_ready=0; offer 0x108 ignored; release id_ready -> 0x100 then 0x104 in order.
- Full buffer, flush=1 with if_valid=1 -> next cycle occupancy=0, id_valid=0, offered pair not stored.
- DEPTH=4, stream 10 pairs with id_ready toggling every cycle -> all 10 delivered in order, pointer wrap exercised, no loss/duplication.
- IFID_STALL_CNT_EN defined, hold id_ready=0 for 5 cycles with id_valid=1 -> stall_cnt=5; undefined -> stall_cnt=0.
